// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer
//   Receive front end for the command parser. The rx pin is brought into the
//   clock domain through a two-flop synchroniser, 8N1 frames are deserialised
//   LSB first, and each good byte is queued in a first-word-fall-through FIFO
//   that the parser drains at its own pace.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   rx           serial input, idles high
//   read         pop the head entry; ignored while empty
//   read_data    FIFO head, valid whenever empty==0
//   empty        FIFO holds no entries
//   full         FIFO holds BUFFER_SIZE entries
//   count        current occupancy
//   frame_error  1-cycle pulse: stop bit sampled low, byte discarded
//   overflow     1-cycle pulse: byte dropped because the FIFO was full
module uart_rx_buffer #(
    parameter int CLK_FREQ     = 25000000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8,
    parameter int BUFFER_SIZE  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rx,
    input  logic                           read,
    output logic [PAYLOAD_BITS-1:0]        read_data,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(BUFFER_SIZE):0]   count,
    output logic                           frame_error,
    output logic                           overflow
);

    localparam int CPB    = CLK_FREQ / BIT_RATE;
    localparam int HALF   = CPB / 2;
    localparam int TICK_W = $clog2(CPB) + 1;
    localparam int BIT_W  = $clog2(PAYLOAD_BITS) + 1;
    localparam int PTR_W  = $clog2(BUFFER_SIZE);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(HALF - 1);
    localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(CPB - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PAYLOAD_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BUFFER_SIZE);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                  state, state_nx;
    logic [TICK_W-1:0]       tick, tick_nx;
    logic [BIT_W-1:0]        bit_cnt, bit_nx;
    logic                    rx_p0, rx_p1;
    logic                    shift_en;
    logic [PAYLOAD_BITS-1:0] shift_p0;
    logic                    byte_vld_nx, byte_vld_p0;
    logic                    ferr_nx;

    logic [PAYLOAD_BITS-1:0] mem [BUFFER_SIZE];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr, rd_ptr_inc;
    logic [CNT_W-1:0]        count_nx;
    logic [PAYLOAD_BITS-1:0] rd_data_nx;
    logic                    do_pop, do_push, ovf_nx;

    // ---- stage: rx synchroniser (rx_p1 lags rx by two cycles) ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end

    // ---- stage: frame FSM ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tick        <= '0;
            bit_cnt     <= '0;
            byte_vld_p0 <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_nx;
            tick        <= tick_nx;
            bit_cnt     <= bit_nx;
            byte_vld_p0 <= byte_vld_nx;
            frame_error <= ferr_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        tick_nx     = tick + 1'b1;
        bit_nx      = bit_cnt;
        shift_en    = 1'b0;
        byte_vld_nx = 1'b0;
        ferr_nx     = 1'b0;
        case (state)
            IDLE: begin
                tick_nx = '0;
                bit_nx  = '0;
                if (!rx_p1) state_nx = START;
            end
            START: begin
                // Re-check the line half a bit in; a high level means the
                // falling edge was a glitch and is dropped silently.
                if (tick == TICK_HALF) begin
                    tick_nx  = '0;
                    state_nx = rx_p1 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick == TICK_FULL) begin
                    tick_nx  = '0;
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_nx   = '0;
                        state_nx = STOP;
                    end else begin
                        bit_nx = bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit lets IDLE catch a start bit that
                // follows immediately.
                if (tick == TICK_FULL) begin
                    tick_nx  = '0;
                    state_nx = IDLE;
                    if (rx_p1) byte_vld_nx = 1'b1;
                    else       ferr_nx     = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Shift register holds the byte until it is pushed; it is not touched
    // again until the next frame's first data sample.
    always_ff @(posedge clk) begin
        if (shift_en) shift_p0 <= {rx_p1, shift_p0[PAYLOAD_BITS-1:1]};
    end

    // ---- stage: FWFT FIFO ----
    assign empty      = (count == '0);
    assign full       = (count == CNT_FULL);
    assign rd_ptr_inc = rd_ptr + 1'b1;

    always_comb begin
        do_pop  = read && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push = byte_vld_p0 && (!full || do_pop);
        ovf_nx  = byte_vld_p0 && full && !read;

        count_nx = count;
        if (do_push && !do_pop)      count_nx = count + 1'b1;
        else if (do_pop && !do_push) count_nx = count - 1'b1;

        // Head register: next stored entry after a pop, or the incoming byte
        // when it becomes the only entry.
        rd_data_nx = read_data;
        if (do_pop) begin
            if (count != CNT_ONE)  rd_data_nx = mem[rd_ptr_inc];
            else if (do_push)      rd_data_nx = shift_p0;
        end else if (do_push && empty) begin
            rd_data_nx = shift_p0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            read_data <= '0;
            overflow  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr_inc;
            count     <= count_nx;
            read_data <= rd_data_nx;
            overflow  <= ovf_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shift_p0;
    end

endmodule
